// File: rtl/uart_rx_receiver_pkg.sv
// Shared UART definitions: default baud divisor and receiver FSM encodings.
// The transmitter on the same board uses the same constants.
package uart_rx_receiver_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_9600 = 1250;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_receiver_if.sv
// Consumer-side bundle of the UART receiver: byte holding register handshake plus status pulses.
interface uart_rx_receiver_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output rx_frame_err,
        output rx_overrun,
        output rx_busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  rx_frame_err,
        input  rx_overrun,
        input  rx_busy
    );

endinterface

// File: rtl/uart_rx_receiver_sync_ff.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_receiver_sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_12mhz,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready holding register and
// framing-error / overrun pulses.
module uart_rx_receiver
    import uart_rx_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  clk_12mhz,
    input  logic                  reset,
    input  logic                  uart_rx,
    uart_rx_receiver_if.master    rx_if
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    logic rxs;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    uart_rx_receiver_sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_12mhz (clk_12mhz),
        .reset     (reset),
        .d         (uart_rx),
        .q         (rxs)
    );

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q & ~rx_if.rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d    = ST_START;
                    baud_cnt_d = '0;
                end
            end
            ST_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    state_d    = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    shreg_d[bit_cnt_q] = rxs;
                    baud_cnt_d         = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (rxs) begin
                        // A load in the same cycle as an acceptance wins and keeps valid high.
                        if (!valid_q || rx_if.rx_ready) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_valid     = valid_q;
    assign rx_if.rx_frame_err = frame_err_q;
    assign rx_if.rx_overrun   = overrun_q;
    assign rx_if.rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Directed bench for uart_rx_receiver with a shortened bit period to keep frames short.
module tb_uart_rx_receiver;

    localparam int unsigned CPB  = 64;
    localparam int unsigned SYNC = 2;
    // Start-bit edge on uart_rx to rx_valid high: 9.5 bit times + sync flops + 1.
    localparam int unsigned LATENCY = (19 * CPB) / 2 + SYNC + 1;

    logic clk_12mhz;
    logic reset;
    logic uart_rx;

    uart_rx_receiver_if rx_if ();

    uart_rx_receiver #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk_12mhz (clk_12mhz),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_if     (rx_if)
    );

    initial clk_12mhz = 1'b0;
    always #5 clk_12mhz = ~clk_12mhz;

    int total = 0;
    int bad   = 0;

    // Free-running cycle counter and output monitor (sampled on the falling edge).
    int   cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    int   acc_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    int   err_cnt = 0;
    int   ovr_cnt = 0;
    bit   prev_valid = 1'b0;
    int   start_cyc = 0;

    always @(posedge clk_12mhz) cyc <= cyc + 1;

    always @(negedge clk_12mhz) begin
        if (rx_if.rx_valid && !prev_valid) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        prev_valid = rx_if.rx_valid;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_data = rx_if.rx_data;
        end
        if (rx_if.rx_frame_err) err_cnt = err_cnt + 1;
        if (rx_if.rx_overrun)   ovr_cnt = ovr_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_12mhz);
        #1;
    endtask

    // Drive the first nbits of an 8N1 frame; per_x100 is the sender bit period in cycles x100.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                               input int unsigned per_x100, input int nbits);
        logic [9:0] bits;
        int unsigned t;
        int unsigned end_c;
        bits = {stop_bit, b, 1'b0};
        t = 0;
        start_cyc = cyc;
        for (int k = 0; k < nbits; k++) begin
            uart_rx = bits[k];
            end_c = ((k + 1) * per_x100) / 100;
            while (t < end_c) begin
                @(posedge clk_12mhz);
                #1;
                t++;
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        uart_rx = 1'b1;
        rx_if.rx_ready = 1'b1;
        wait_cycles(3);
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid got=%b want=0", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 8'h00) begin bad++;
            $display("FAIL reset_data got=%h want=00", rx_if.rx_data); end
        total++; if (rx_if.rx_frame_err !== 1'b0) begin bad++;
            $display("FAIL reset_ferr got=%b want=0", rx_if.rx_frame_err); end
        total++; if (rx_if.rx_overrun !== 1'b0) begin bad++;
            $display("FAIL reset_ovr got=%b want=0", rx_if.rx_overrun); end
        total++; if (rx_if.rx_busy !== 1'b0) begin bad++;
            $display("FAIL reset_busy got=%b want=0", rx_if.rx_busy); end
        reset = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_basic();
        int r0, a0, e0, o0;
        r0 = rise_cnt; a0 = acc_cnt; e0 = err_cnt; o0 = ovr_cnt;
        rx_if.rx_ready = 1'b1;
        drive_frame(8'h77, 1'b1, CPB * 100, 10);
        wait_cycles(CPB);
        total++; if (rise_cnt - r0 !== 1) begin bad++;
            $display("FAIL basic_rises got=%0d want=1", rise_cnt - r0); end
        total++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h77) begin bad++;
            $display("FAIL basic_data got=%h n=%0d want=77 n=1", acc_data, acc_cnt - a0); end
        total++; if (rise_cyc - start_cyc !== LATENCY) begin bad++;
            $display("FAIL basic_latency got=%0d want=%0d", rise_cyc - start_cyc, LATENCY); end
        total++; if (err_cnt - e0 !== 0 || ovr_cnt - o0 !== 0) begin bad++;
            $display("FAIL basic_pulses got err=%0d ovr=%0d want 0 0", err_cnt - e0, ovr_cnt - o0); end
        total++; if (rx_if.rx_valid !== 1'b0 || rx_if.rx_busy !== 1'b0) begin bad++;
            $display("FAIL basic_idle got valid=%b busy=%b want 0 0", rx_if.rx_valid, rx_if.rx_busy); end
    endtask

    task automatic test_glitch();
        int r0, e0;
        r0 = rise_cnt; e0 = err_cnt;
        uart_rx = 1'b0;
        wait_cycles(10);
        total++; if (rx_if.rx_busy !== 1'b1) begin bad++;
            $display("FAIL glitch_busy got=%b want=1", rx_if.rx_busy); end
        wait_cycles((3 * CPB) / 10 - 10);
        uart_rx = 1'b1;
        wait_cycles(CPB);
        total++; if (rx_if.rx_busy !== 1'b0) begin bad++;
            $display("FAIL glitch_idle got=%b want=0", rx_if.rx_busy); end
        total++; if (rise_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin bad++;
            $display("FAIL glitch_pulses got rises=%0d errs=%0d want 0 0",
                     rise_cnt - r0, err_cnt - e0); end
    endtask

    task automatic test_frame_err();
        int r0, e0;
        r0 = rise_cnt; e0 = err_cnt;
        drive_frame(8'hA5, 1'b0, CPB * 100, 10);
        uart_rx = 1'b0;
        wait_cycles(2 * CPB);
        total++; if (rx_if.rx_busy !== 1'b1) begin bad++;
            $display("FAIL ferr_break_busy got=%b want=1", rx_if.rx_busy); end
        uart_rx = 1'b1;
        wait_cycles(10);
        total++; if (err_cnt - e0 !== 1) begin bad++;
            $display("FAIL ferr_count got=%0d want=1", err_cnt - e0); end
        total++; if (rise_cnt - r0 !== 0 || rx_if.rx_valid !== 1'b0) begin bad++;
            $display("FAIL ferr_valid got rises=%0d valid=%b want 0 0",
                     rise_cnt - r0, rx_if.rx_valid); end
        total++; if (rx_if.rx_busy !== 1'b0) begin bad++;
            $display("FAIL ferr_idle got=%b want=0", rx_if.rx_busy); end
    endtask

    task automatic test_overrun();
        int r0, o0, a0;
        r0 = rise_cnt; o0 = ovr_cnt; a0 = acc_cnt;
        rx_if.rx_ready = 1'b0;
        drive_frame(8'h11, 1'b1, CPB * 100, 10);
        drive_frame(8'h22, 1'b1, CPB * 100, 10);
        wait_cycles(20);
        total++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11) begin bad++;
            $display("FAIL ovr_hold got valid=%b data=%h want 1 11",
                     rx_if.rx_valid, rx_if.rx_data); end
        total++; if (ovr_cnt - o0 !== 1) begin bad++;
            $display("FAIL ovr_count got=%0d want=1", ovr_cnt - o0); end
        total++; if (rise_cnt - r0 !== 1) begin bad++;
            $display("FAIL ovr_rises got=%0d want=1", rise_cnt - r0); end
        rx_if.rx_ready = 1'b1;
        wait_cycles(1);
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++;
            $display("FAIL ovr_accept got=%b want=0", rx_if.rx_valid); end
        total++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h11) begin bad++;
            $display("FAIL ovr_accept_data got=%h n=%0d want=11 n=1", acc_data, acc_cnt - a0); end
    endtask

    task automatic test_reset_mid();
        int r0, e0, o0;
        // Leave a byte pending so the reset has something to clear.
        rx_if.rx_ready = 1'b0;
        drive_frame(8'h99, 1'b1, CPB * 100, 10);
        wait_cycles(4);
        r0 = rise_cnt; e0 = err_cnt; o0 = ovr_cnt;
        drive_frame(8'h3C, 1'b1, CPB * 100, 5);
        total++; if (rx_if.rx_busy !== 1'b1) begin bad++;
            $display("FAIL rmid_busy got=%b want=1", rx_if.rx_busy); end
        reset = 1'b1;
        uart_rx = 1'b1;
        wait_cycles(2);
        total++; if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || rx_if.rx_busy !== 1'b0)
            begin bad++;
            $display("FAIL rmid_reset got valid=%b data=%h busy=%b want 0 00 0",
                     rx_if.rx_valid, rx_if.rx_data, rx_if.rx_busy); end
        reset = 1'b0;
        rx_if.rx_ready = 1'b1;
        wait_cycles(CPB);
        drive_frame(8'h5A, 1'b1, CPB * 100, 10);
        wait_cycles(CPB);
        total++; if (rise_cnt - r0 !== 1 || acc_data !== 8'h5A) begin bad++;
            $display("FAIL rmid_data got=%h rises=%0d want=5a rises=1", acc_data, rise_cnt - r0); end
        total++; if (err_cnt - e0 !== 0 || ovr_cnt - o0 !== 0) begin bad++;
            $display("FAIL rmid_pulses got err=%0d ovr=%0d want 0 0", err_cnt - e0, ovr_cnt - o0); end
    endtask

    task automatic test_baud_tolerance();
        logic [7:0] pat [3];
        int unsigned per [2];
        int a0, e0;
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
        per[0] = CPB * 98;
        per[1] = CPB * 102;
        rx_if.rx_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                a0 = acc_cnt; e0 = err_cnt;
                drive_frame(pat[i], 1'b1, per[p], 10);
                wait_cycles(2);
                total++; if (acc_cnt - a0 !== 1 || acc_data !== pat[i] || err_cnt - e0 !== 0)
                    begin bad++;
                    $display("FAIL tol_%0d_%0d got=%h n=%0d err=%0d want=%h n=1 err=0",
                             per[p], i, acc_data, acc_cnt - a0, err_cnt - e0, pat[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_baud_tolerance();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
